// File: rtl/ssc_pkg.sv
// Shared types and helpers for the Super Serial Card RX line conditioner.
package ssc_pkg;

    typedef enum logic [1:0] {S_MARK, S_IDLE, S_SPACE, S_BREAK} ssc_rx_line_state_t;

    localparam int unsigned SSC_GLITCH_MAX = 255;

    function automatic int unsigned ssc_bit_clks(input int unsigned hz, input int unsigned baud);
        return hz / baud;
    endfunction

    function automatic int unsigned ssc_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ssc_rx_glitch_filter.sv
// RX pin synchroniser, loopback source select, stable-count glitch filter and
// saturating glitch counter.
module ssc_rx_glitch_filter
    import ssc_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic       clk_logic,
    input  logic       system_reset_n,
    input  logic       uart_rx_raw_i,
    input  logic       uart_tx_i,
    input  logic       loopback_i,
    output logic       uart_rx_o,
    output logic       rx_change_o,
    output logic [7:0] glitch_count_o
);
    localparam int unsigned CW = $clog2(FILTER_LEN);

    logic          sync_meta_q;
    logic          sync_q;
    logic          rx_q;
    logic [CW-1:0] dcnt_q;
    logic [7:0]    gcnt_q;
    logic          src;
    logic          differ;
    logic          accept;

    // uart_tx_i already lives in clk_logic, so loopback bypasses the synchroniser.
    assign src    = loopback_i ? uart_tx_i : sync_q;
    assign differ = (src != rx_q);
    assign accept = differ && (dcnt_q == CW'(FILTER_LEN - 1));

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            sync_meta_q <= 1'b1;
            sync_q      <= 1'b1;
            rx_q        <= 1'b1;
            dcnt_q      <= '0;
            gcnt_q      <= '0;
        end else begin
            sync_meta_q <= uart_rx_raw_i;
            sync_q      <= sync_meta_q;
            if (accept) begin
                rx_q   <= src;
                dcnt_q <= '0;
            end else if (differ) begin
                dcnt_q <= dcnt_q + 1'b1;
            end else begin
                dcnt_q <= '0;
                // A partial run that collapsed before acceptance is a rejected glitch.
                if (dcnt_q != '0 && gcnt_q != 8'(SSC_GLITCH_MAX)) begin
                    gcnt_q <= gcnt_q + 1'b1;
                end
            end
        end
    end

    assign uart_rx_o      = rx_q;
    assign rx_change_o    = accept;
    assign glitch_count_o = gcnt_q;

endmodule

// File: rtl/ssc_rx_line_conditioner.sv
// SSC RX line conditioner: filtered RX plus mark/idle/space/break classification.
// Optional activity LED stretcher enabled by SSC_RX_ACTIVITY_LED_EN.
module ssc_rx_line_conditioner
    import ssc_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED_HZ = 54_000_000,
    parameter int unsigned BAUD_RATE      = 115_200,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned IDLE_BITS      = 10,
    parameter int unsigned BREAK_BITS     = 12,
    parameter int unsigned LED_HOLD_MS    = 50
) (
    input  logic       clk_logic,
    input  logic       system_reset_n,
    input  logic       uart_rx_raw_i,
    input  logic       uart_tx_i,
    input  logic       loopback_i,
    output logic       uart_rx_o,
    output logic       idle_o,
    output logic       break_o,
    output logic [7:0] glitch_count_o
`ifdef SSC_RX_ACTIVITY_LED_EN
    ,
    output logic       led_o
`endif
);
    localparam int unsigned BIT_CLKS  = ssc_bit_clks(CLOCK_SPEED_HZ, BAUD_RATE);
    localparam int unsigned IDLE_LIM  = IDLE_BITS * BIT_CLKS;
    localparam int unsigned BREAK_LIM = BREAK_BITS * BIT_CLKS;
    localparam int unsigned RUN_W     = $clog2(ssc_max(IDLE_LIM, BREAK_LIM) + 1);

    if (BIT_CLKS < 4 * FILTER_LEN) begin : g_chk_filter
        $error("BIT_CLKS must be at least 4*FILTER_LEN");
    end
    if (IDLE_BITS == 0 || BREAK_BITS == 0) begin : g_chk_bits
        $error("IDLE_BITS and BREAK_BITS must be non-zero");
    end
    if (LED_HOLD_MS == 0) begin : g_chk_led
        $error("LED_HOLD_MS must be non-zero");
    end

    logic               rx_change;
    logic [RUN_W-1:0]   run_q;
    ssc_rx_line_state_t state_q;
    logic               idle_q;
    logic               break_q;

    ssc_rx_glitch_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filter (
        .clk_logic     (clk_logic),
        .system_reset_n(system_reset_n),
        .uart_rx_raw_i (uart_rx_raw_i),
        .uart_tx_i     (uart_tx_i),
        .loopback_i    (loopback_i),
        .uart_rx_o     (uart_rx_o),
        .rx_change_o   (rx_change),
        .glitch_count_o(glitch_count_o)
    );

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            run_q <= '0;
        end else if (rx_change) begin
            run_q <= '0;
        end else if (run_q != RUN_W'(BREAK_LIM)) begin
            run_q <= run_q + 1'b1;
        end
    end

    // Level changes are tested before limit hits so a transition always wins.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= S_MARK;
            idle_q  <= 1'b0;
            break_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_MARK: begin
                    if (!uart_rx_o) begin
                        state_q <= S_SPACE;
                    end else if (run_q == RUN_W'(IDLE_LIM - 1)) begin
                        state_q <= S_IDLE;
                        idle_q  <= 1'b1;
                    end
                end
                S_IDLE: begin
                    if (!uart_rx_o) begin
                        state_q <= S_SPACE;
                        idle_q  <= 1'b0;
                    end
                end
                S_SPACE: begin
                    if (uart_rx_o) begin
                        state_q <= S_MARK;
                    end else if (run_q == RUN_W'(BREAK_LIM - 1)) begin
                        state_q <= S_BREAK;
                        break_q <= 1'b1;
                    end
                end
                S_BREAK: begin
                    if (uart_rx_o) begin
                        state_q <= S_MARK;
                        break_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_MARK;
                    idle_q  <= 1'b0;
                    break_q <= 1'b0;
                end
            endcase
        end
    end

    assign idle_o  = idle_q;
    assign break_o = break_q;

`ifdef SSC_RX_ACTIVITY_LED_EN
    localparam int unsigned LED_LOAD = LED_HOLD_MS * (CLOCK_SPEED_HZ / 1000) - 1;
    localparam int unsigned LED_W    = $clog2(ssc_max(LED_LOAD, 1) + 1);

    logic [LED_W-1:0] led_cnt_q;
    logic             led_q;

    // rx_change while uart_rx_o is still 1 marks a filtered falling edge.
    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            led_cnt_q <= '0;
            led_q     <= 1'b0;
        end else if (rx_change && uart_rx_o) begin
            led_cnt_q <= LED_W'(LED_LOAD);
            led_q     <= 1'b1;
        end else if (led_cnt_q != '0) begin
            led_cnt_q <= led_cnt_q - 1'b1;
        end else begin
            led_q <= 1'b0;
        end
    end

    assign led_o = led_q;
`endif

endmodule
